unidade_controle_param: RTL and testbench
=========================================

# unidade_controle_param

Parametrised, next-generation control unit for the multi-cycle processor: fetches 16-bit instructions, decodes them, and drives the data memory, register file, and ALU select lines. It sits between instruction memory, data memory, and the datapath (register file and ALU). Relative to the six-instruction unit it adds:
- configurable data, address and PC widths;
- ready handshakes on both memories (wait states);
- three new opcodes (JMP, JMPNZ, HALT);
- halted and illegal-opcode status outputs.

## Interface
Parameters:
- DW, 8, datapath width; RF_W_data width.
- DAW, 8, data memory address width; must be ≤ 8 (the direct-address field is 8 bits, zero-extended).
- PCW, 16, program counter and I_addr width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- I_addr  out  PCW  instruction address = PC.
- I_rd  out  1  instruction read request.
- I_ready  in  1  instruction word valid on I_data this cycle.
- I_data  in  16  instruction word.
- D_addr  out  DAW  data address.
- D_rd, D_wr  out  1 each  data read / write strobes.
- D_ready  in  1  data access completes this cycle.
- RF_W_data  out  DW  constant IR[7:0] sign-extended to DW.
- RF_sel  out  2  write-source select: 00 ALU, 01 memory, 10 constant.
- RF_W_addr, RF_Rp_addr, RF_Rq_addr  out  4 each  register addresses.
- RF_W_wr, RF_Rp_rd, RF_Rq_rd  out  1 each  register file strobes.
- RF_Rp_zero  in  1  Rp read data equals zero.
- alu_sel  out  2  ALU operation: 00 pass, 01 add, 10 sub.
- halted  out  1  core is stopped in PARADO.
- illegal  out  1  sticky; an undefined opcode was decoded.

## Operation
Instruction fields:
- op = IR[15:12], Ra = IR[11:8], Rb = IR[7:4], Rc = IR[3:0].
- d = IR[7:0], used as an unsigned address, a signed constant, or a signed jump offset.

Opcodes:
- 0 MOVR: Ra ← M[d].
- 1 MOVD: M[d] ← Ra.
- 2 ADD: Ra ← Rb + Rc.
- 3 MOVC: Ra ← sext(d).
- 4 SUB: Ra ← Rb − Rc.
- 5 JMPZ: jump if Ra == 0.
- 6 JMP: jump unconditionally.
- 7 JMPNZ: jump if Ra != 0.
- 15 HALT: stop.
- Any other opcode: set illegal, treat as NOP, return to BUSCA.

States: INICIO, BUSCA, DECOD, CARREGAR, ARMAZENAR, SOMAR, CARREGAR_CONST, SUBTRAIR, SALTAR_COND, SALTAR, PARADO.
- INICIO: PC cleared to 0; next state BUSCA.
- BUSCA: I_rd = 1. Remain in BUSCA while I_ready = 0. When I_ready = 1: IR ← I_data, PC ← PC + 1, next state DECOD.
- DECOD: no strobes. Selects the next state from op; JMP goes directly to SALTAR.
- CARREGAR: D_addr = d, D_rd = 1, RF_sel = 01, RF_W_addr = Ra. RF_W_wr = 1 only in the cycle D_ready = 1; next state BUSCA on that cycle.
- ARMAZENAR: D_addr = d, D_wr = 1, RF_Rp_addr = Ra, RF_Rp_rd = 1. Remain in ARMAZENAR until D_ready = 1, then BUSCA.
- SOMAR / SUBTRAIR: Rp = Rb, Rq = Rc, W = Ra, both reads and the write asserted, RF_sel = 00, alu_sel = 01 / 10; next state BUSCA.
- CARREGAR_CONST: RF_sel = 10, RF_W_addr = Ra, RF_W_wr = 1; next state BUSCA.
- SALTAR_COND: RF_Rp_addr = Ra, RF_Rp_rd = 1. Goes to SALTAR if RF_Rp_zero == (op == JMPZ), otherwise BUSCA.
- SALTAR: PC ← PC + sext(d) − 1, i.e. the jump instruction's address + offset, modulo 2^PCW. Next state BUSCA.
- PARADO: halted = 1, all strobes 0. Left only by reset.

Outputs not named for a state are 0.

## Timing
- Reset (reset_n = 0, asynchronous): state = INICIO, IR = 0, PC = 0, illegal = 0; all outputs 0 except RF_W_data = 0.
- Reset asserted mid-access drops I_rd, D_rd and D_wr immediately.
- Cycle counts with zero wait states:
  - MOVC, ADD, SUB: 3 cycles.
  - MOVR, MOVD: 3 cycles, plus one for each D_ready = 0 cycle.
  - JMP: 3 cycles.
  - JMPZ / JMPNZ: 4 cycles when taken, 3 when not taken.
  - HALT: reaches PARADO after 2 cycles.
- Each I_ready = 0 cycle adds one BUSCA cycle. PC and IR hold during the stall.
- I_addr is stable for the whole BUSCA period.
- Strobes are combinational from state plus the ready inputs. There is no registered output latency.
- PC wraps from 2^PCW − 1 to 0 on increment. Negative offsets wrap the same way.
- illegal stays 1 until reset, even after later legal instructions.

## Structure
- Package proc_pkg holds:
  - the statetype enum (4-bit);
  - the opcode enum;
  - localparams for the RF_sel and alu_sel encodings.
- Sub-module pc_reg (parametrised by PCW) provides clr, inc and ld with sign-extended offset. Priority is clr > inc > ld.
- IR register and FSM are inline.

## Test plan
- Release reset; MOVC R1,0x05 with I_ready tied 1 → I_addr sequence 0, 1. At CARREGAR_CONST: RF_sel = 10, RF_W_addr = 1, RF_W_data = 0x05; RF_W_wr pulses once.
- MOVC R2,0xFF with DW = 16 → RF_W_data = 0xFFFF.
- MOVR R3,[0x10] with D_ready low for 2 cycles → D_rd held 3 cycles at D_addr = 0x10; RF_W_wr asserted only in the final cycle.
- JMPZ R1,−2 at address 4 with RF_Rp_zero = 1 → next fetch at I_addr = 2.
- Same with RF_Rp_zero = 0 → next fetch at 5. JMPNZ shows the inverse behaviour.
- Opcode 0xA → illegal = 1 and the next fetch proceeds. HALT → halted = 1, I_rd = 0 indefinitely.
- reset_n pulsed low during an I_ready stall → I_rd = 0 in the same cycle; after release, fetch restarts at I_addr = 0.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared types for the multi-cycle control unit: FSM states, opcodes, select encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package proc_pkg;

  // FSM state encoding; 11 states fit in 4 bits.
  typedef enum logic [3:0] {
    INICIO,
    BUSCA,
    DECOD,
    CARREGAR,
    ARMAZENAR,
    SOMAR,
    CARREGAR_CONST,
    SUBTRAIR,
    SALTAR_COND,
    SALTAR,
    PARADO
  } statetype;

  // Instruction opcodes held in IR[15:12]; values not listed are undefined.
  typedef enum logic [3:0] {
    OP_MOVR  = 4'h0,
    OP_MOVD  = 4'h1,
    OP_ADD   = 4'h2,
    OP_MOVC  = 4'h3,
    OP_SUB   = 4'h4,
    OP_JMPZ  = 4'h5,
    OP_JMP   = 4'h6,
    OP_JMPNZ = 4'h7,
    OP_HALT  = 4'hF
  } opcode_t;

  // Register-file write source select.
  localparam logic [1:0] RF_SEL_ALU   = 2'b00;
  localparam logic [1:0] RF_SEL_MEM   = 2'b01;
  localparam logic [1:0] RF_SEL_CONST = 2'b10;

  // ALU operation select.
  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

endpackage

// File: rtl/pc_reg.sv
// Program counter with clear, increment and relative load (priority clr > inc > ld).
// Latency: new value visible one clk after the request.
// Backpressure: none; caller sequences the requests.
//
// Ports: clk, reset_n (async active-low), clr, inc, ld, off (8-bit signed offset), pc.
module pc_reg #(
  parameter int PCW = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clr,
  input  logic           inc,
  input  logic           ld,
  input  logic [7:0]     off,
  output logic [PCW-1:0] pc
);

  localparam logic [PCW-1:0] ONE = PCW'(1);

  logic [PCW-1:0] off_ext;

  // By the time a jump executes, pc already points past the jump
  // instruction, so the -1 makes the offset relative to the jump itself.
  assign off_ext = PCW'($signed(off));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= '0;
    end else if (clr) begin
      pc <= '0;
    end else if (inc) begin
      pc <= pc + ONE;
    end else if (ld) begin
      pc <= pc + off_ext - ONE;
    end
  end

endmodule

// File: rtl/unidade_controle_param.sv
// Multi-cycle control unit: fetch/decode 16-bit instructions, drive data memory, register file, ALU.
// Latency: 3 cycles per instruction (4 for a taken conditional jump), plus wait states.
// Backpressure: I_ready=0 stalls in BUSCA, D_ready=0 stalls in CARREGAR/ARMAZENAR.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   I_addr/I_rd/I_ready/I_data   instruction memory (I_addr = PC)
//   D_addr/D_rd/D_wr/D_ready     data memory
//   RF_*                         register-file addresses, strobes, write source and constant
//   alu_sel                      ALU operation
//   halted, illegal              status (illegal is sticky until reset)
module unidade_controle_param
  import proc_pkg::*;
#(
  parameter int DW  = 8,
  parameter int DAW = 8,
  parameter int PCW = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  output logic [PCW-1:0] I_addr,
  output logic           I_rd,
  input  logic           I_ready,
  input  logic [15:0]    I_data,
  output logic [DAW-1:0] D_addr,
  output logic           D_rd,
  output logic           D_wr,
  input  logic           D_ready,
  output logic [DW-1:0]  RF_W_data,
  output logic [1:0]     RF_sel,
  output logic [3:0]     RF_W_addr,
  output logic [3:0]     RF_Rp_addr,
  output logic [3:0]     RF_Rq_addr,
  output logic           RF_W_wr,
  output logic           RF_Rp_rd,
  output logic           RF_Rq_rd,
  input  logic           RF_Rp_zero,
  output logic [1:0]     alu_sel,
  output logic           halted,
  output logic           illegal
);

  statetype       state;
  logic [15:0]    ir;
  opcode_t        op;
  logic [3:0]     ra, rb, rc;
  logic [7:0]     d;
  logic           pc_clr, pc_inc, pc_ld;
  logic [PCW-1:0] pc;

  assign op = opcode_t'(ir[15:12]);
  assign ra = ir[11:8];
  assign rb = ir[7:4];
  assign rc = ir[3:0];
  assign d  = ir[7:0];

  // The constant is always presented; it only matters when RF_sel selects it.
  assign RF_W_data = DW'($signed(d));

  assign I_addr = pc;
  assign halted = (state == PARADO);

  assign pc_clr = (state == INICIO);
  assign pc_inc = (state == BUSCA) && I_ready;
  assign pc_ld  = (state == SALTAR);

  pc_reg #(
    .PCW (PCW)
  ) u_pc (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (pc_clr),
    .inc     (pc_inc),
    .ld      (pc_ld),
    .off     (d),
    .pc      (pc)
  );

  // State, IR and sticky illegal flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= INICIO;
      ir      <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        INICIO: state <= BUSCA;
        BUSCA: begin
          if (I_ready) begin
            ir    <= I_data;
            state <= DECOD;
          end
        end
        DECOD: begin
          case (op)
            OP_MOVR:  state <= CARREGAR;
            OP_MOVD:  state <= ARMAZENAR;
            OP_ADD:   state <= SOMAR;
            OP_MOVC:  state <= CARREGAR_CONST;
            OP_SUB:   state <= SUBTRAIR;
            OP_JMPZ:  state <= SALTAR_COND;
            OP_JMPNZ: state <= SALTAR_COND;
            OP_JMP:   state <= SALTAR;
            OP_HALT:  state <= PARADO;
            default: begin
              // Undefined opcode executes as a NOP but is remembered.
              illegal <= 1'b1;
              state   <= BUSCA;
            end
          endcase
        end
        CARREGAR:       if (D_ready) state <= BUSCA;
        ARMAZENAR:      if (D_ready) state <= BUSCA;
        SOMAR:          state <= BUSCA;
        SUBTRAIR:       state <= BUSCA;
        CARREGAR_CONST: state <= BUSCA;
        SALTAR_COND: begin
          // JMPZ jumps on zero, JMPNZ on non-zero.
          if (RF_Rp_zero == (op == OP_JMPZ)) state <= SALTAR;
          else                               state <= BUSCA;
        end
        SALTAR:  state <= BUSCA;
        PARADO:  state <= PARADO;
        default: state <= INICIO;
      endcase
    end
  end

  // Strobes are combinational from state and the ready inputs so that a
  // wait state or reset takes effect within the same cycle.
  always_comb begin
    I_rd       = 1'b0;
    D_addr     = '0;
    D_rd       = 1'b0;
    D_wr       = 1'b0;
    RF_sel     = RF_SEL_ALU;
    RF_W_addr  = '0;
    RF_Rp_addr = '0;
    RF_Rq_addr = '0;
    RF_W_wr    = 1'b0;
    RF_Rp_rd   = 1'b0;
    RF_Rq_rd   = 1'b0;
    alu_sel    = ALU_PASS;
    case (state)
      BUSCA: I_rd = 1'b1;
      CARREGAR: begin
        D_addr    = d[DAW-1:0];
        D_rd      = 1'b1;
        RF_sel    = RF_SEL_MEM;
        RF_W_addr = ra;
        RF_W_wr   = D_ready;
      end
      ARMAZENAR: begin
        D_addr     = d[DAW-1:0];
        D_wr       = 1'b1;
        RF_Rp_addr = ra;
        RF_Rp_rd   = 1'b1;
      end
      SOMAR, SUBTRAIR: begin
        RF_Rp_addr = rb;
        RF_Rq_addr = rc;
        RF_W_addr  = ra;
        RF_Rp_rd   = 1'b1;
        RF_Rq_rd   = 1'b1;
        RF_W_wr    = 1'b1;
        RF_sel     = RF_SEL_ALU;
        alu_sel    = (state == SOMAR) ? ALU_ADD : ALU_SUB;
      end
      CARREGAR_CONST: begin
        RF_sel    = RF_SEL_CONST;
        RF_W_addr = ra;
        RF_W_wr   = 1'b1;
      end
      SALTAR_COND: begin
        RF_Rp_addr = ra;
        RF_Rp_rd   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle_param.sv
// Directed self-checking bench for unidade_controle_param (DW=16, DAW=8, PCW=16).
// Latency: n/a.
// Backpressure: exercises I_ready and D_ready wait states.
module tb_unidade_controle_param;

  localparam int DW  = 16;
  localparam int DAW = 8;
  localparam int PCW = 16;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [PCW-1:0] I_addr;
  logic           I_rd;
  logic           I_ready;
  logic [15:0]    I_data;
  logic [DAW-1:0] D_addr;
  logic           D_rd;
  logic           D_wr;
  logic           D_ready;
  logic [DW-1:0]  RF_W_data;
  logic [1:0]     RF_sel;
  logic [3:0]     RF_W_addr;
  logic [3:0]     RF_Rp_addr;
  logic [3:0]     RF_Rq_addr;
  logic           RF_W_wr;
  logic           RF_Rp_rd;
  logic           RF_Rq_rd;
  logic           RF_Rp_zero;
  logic [1:0]     alu_sel;
  logic           halted;
  logic           illegal;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  unidade_controle_param #(
    .DW  (DW),
    .DAW (DAW),
    .PCW (PCW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .I_addr     (I_addr),
    .I_rd       (I_rd),
    .I_ready    (I_ready),
    .I_data     (I_data),
    .D_addr     (D_addr),
    .D_rd       (D_rd),
    .D_wr       (D_wr),
    .D_ready    (D_ready),
    .RF_W_data  (RF_W_data),
    .RF_sel     (RF_sel),
    .RF_W_addr  (RF_W_addr),
    .RF_Rp_addr (RF_Rp_addr),
    .RF_Rq_addr (RF_Rq_addr),
    .RF_W_wr    (RF_W_wr),
    .RF_Rp_rd   (RF_Rp_rd),
    .RF_Rq_rd   (RF_Rq_rd),
    .RF_Rp_zero (RF_Rp_zero),
    .alu_sel    (alu_sel),
    .halted     (halted),
    .illegal    (illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Move to 2 time units after the next rising edge, then let inputs settle.
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Called while in BUSCA: checks the fetch address, supplies the word, and
  // leaves the unit in DECOD.
  task automatic fetch(input logic [15:0] instr, input logic [15:0] addr, input string tag);
    chk({tag, " busca I_rd"}, 32'(I_rd), 32'd1);
    chk({tag, " busca I_addr"}, 32'(I_addr), 32'(addr));
    I_ready = 1'b1;
    I_data  = instr;
    tick;
    I_ready = 1'b0;
    #1;
    chk({tag, " decod I_rd"}, 32'(I_rd), 32'd0);
  endtask

  initial begin
    reset_n    = 1'b0;
    I_ready    = 1'b0;
    I_data     = 16'h0000;
    D_ready    = 1'b0;
    RF_Rp_zero = 1'b0;
    #12;
    chk("rst I_rd", 32'(I_rd), 32'd0);
    chk("rst I_addr", 32'(I_addr), 32'd0);
    chk("rst halted", 32'(halted), 32'd0);
    chk("rst illegal", 32'(illegal), 32'd0);
    chk("rst RF_W_data", 32'(RF_W_data), 32'd0);
    chk("rst strobes", 32'({D_rd, D_wr, RF_W_wr, RF_Rp_rd, RF_Rq_rd}), 32'd0);
    reset_n = 1'b1;
    tick; #1;

    // MOVC R1,0x05
    fetch(16'h3105, 16'h0000, "movc1");
    chk("movc1 decod I_addr", 32'(I_addr), 32'd1);
    chk("movc1 decod RF_W_wr", 32'(RF_W_wr), 32'd0);
    tick; #1;
    chk("movc1 RF_sel", 32'(RF_sel), 32'd2);
    chk("movc1 RF_W_addr", 32'(RF_W_addr), 32'd1);
    chk("movc1 RF_W_data", 32'(RF_W_data), 32'h0005);
    chk("movc1 RF_W_wr", 32'(RF_W_wr), 32'd1);
    tick; #1;
    chk("movc1 RF_W_wr drop", 32'(RF_W_wr), 32'd0);

    // MOVC R2,0xFF sign-extends to 16 bits
    fetch(16'h32FF, 16'h0001, "movc2");
    tick; #1;
    chk("movc2 RF_W_data", 32'(RF_W_data), 32'hFFFF);
    chk("movc2 RF_W_addr", 32'(RF_W_addr), 32'd2);
    tick; #1;

    // MOVR R3,[0x10] with two wait states
    fetch(16'h0310, 16'h0002, "movr");
    tick; D_ready = 1'b0; #1;
    chk("movr w1 D_rd", 32'(D_rd), 32'd1);
    chk("movr w1 D_addr", 32'(D_addr), 32'h10);
    chk("movr w1 RF_sel", 32'(RF_sel), 32'd1);
    chk("movr w1 RF_W_wr", 32'(RF_W_wr), 32'd0);
    tick; #1;
    chk("movr w2 D_rd", 32'(D_rd), 32'd1);
    chk("movr w2 RF_W_wr", 32'(RF_W_wr), 32'd0);
    tick; D_ready = 1'b1; #1;
    chk("movr done D_rd", 32'(D_rd), 32'd1);
    chk("movr done RF_W_wr", 32'(RF_W_wr), 32'd1);
    chk("movr done RF_W_addr", 32'(RF_W_addr), 32'd3);
    tick; D_ready = 1'b0; #1;
    chk("movr after D_rd", 32'(D_rd), 32'd0);

    // MOVD R4,[0x20] with no wait state
    fetch(16'h1420, 16'h0003, "movd");
    D_ready = 1'b1;
    tick; #1;
    chk("movd D_wr", 32'(D_wr), 32'd1);
    chk("movd D_rd", 32'(D_rd), 32'd0);
    chk("movd D_addr", 32'(D_addr), 32'h20);
    chk("movd Rp", 32'({RF_Rp_rd, RF_Rp_addr}), 32'h14);
    tick; D_ready = 1'b0; #1;

    // JMPZ R1,-2 at 4, taken -> 2
    fetch(16'h51FE, 16'h0004, "jmpz_t");
    RF_Rp_zero = 1'b1;
    tick; #1;
    chk("jmpz_t cond Rp", 32'({RF_Rp_rd, RF_Rp_addr}), 32'h11);
    tick; #1;
    chk("jmpz_t saltar Rp_rd", 32'(RF_Rp_rd), 32'd0);
    chk("jmpz_t saltar I_rd", 32'(I_rd), 32'd0);
    tick; #1;
    RF_Rp_zero = 1'b0;

    // ADD R5,R6,R7
    fetch(16'h2567, 16'h0002, "add");
    tick; #1;
    chk("add strobes", 32'({RF_Rp_rd, RF_Rq_rd, RF_W_wr}), 32'd7);
    chk("add addrs", 32'({RF_W_addr, RF_Rp_addr, RF_Rq_addr}), 32'h567);
    chk("add alu_sel", 32'(alu_sel), 32'd1);
    chk("add RF_sel", 32'(RF_sel), 32'd0);
    tick; #1;

    // SUB R8,R9,R10
    fetch(16'h489A, 16'h0003, "sub");
    tick; #1;
    chk("sub addrs", 32'({RF_W_addr, RF_Rp_addr, RF_Rq_addr}), 32'h89A);
    chk("sub alu_sel", 32'(alu_sel), 32'd2);
    tick; #1;

    // JMPZ R1,-2 at 4, not taken -> 5
    fetch(16'h51FE, 16'h0004, "jmpz_nt");
    tick; #1;
    chk("jmpz_nt cond Rp_rd", 32'(RF_Rp_rd), 32'd1);
    tick; #1;

    // JMPNZ R1,+3 at 5, taken -> 8
    fetch(16'h7103, 16'h0005, "jmpnz_t");
    tick; #1;
    tick; #1;
    chk("jmpnz_t saltar I_rd", 32'(I_rd), 32'd0);
    tick; #1;

    // JMPNZ R1,+3 at 8, not taken -> 9
    fetch(16'h7103, 16'h0008, "jmpnz_nt");
    RF_Rp_zero = 1'b1;
    tick; #1;
    tick; #1;
    RF_Rp_zero = 1'b0;

    // JMP -9 at 9 -> 0, straight from DECOD to SALTAR
    fetch(16'h60F7, 16'h0009, "jmp");
    tick; #1;
    chk("jmp saltar Rp_rd", 32'(RF_Rp_rd), 32'd0);
    chk("jmp saltar I_rd", 32'(I_rd), 32'd0);
    tick; #1;

    // JMP -1 at 0 -> 0xFFFF
    fetch(16'h60FF, 16'h0000, "jmp_wrap");
    tick; #1;
    tick; #1;

    // Undefined opcode at 0xFFFF; PC wraps to 0
    fetch(16'hA000, 16'hFFFF, "illegal");
    chk("illegal decod I_addr", 32'(I_addr), 32'd0);
    chk("illegal decod flag", 32'(illegal), 32'd0);
    tick; #1;
    chk("illegal flag", 32'(illegal), 32'd1);

    // Instruction stall: I_addr holds
    tick; #1;
    chk("stall1 I_rd", 32'(I_rd), 32'd1);
    chk("stall1 I_addr", 32'(I_addr), 32'd0);
    tick; #1;
    chk("stall2 I_addr", 32'(I_addr), 32'd0);

    fetch(16'h3105, 16'h0000, "movc3");
    tick; #1;
    tick; #1;
    chk("illegal sticky", 32'(illegal), 32'd1);

    // HALT at 1
    fetch(16'hF000, 16'h0001, "halt");
    tick; #1;
    chk("halt halted", 32'(halted), 32'd1);
    chk("halt I_rd", 32'(I_rd), 32'd0);
    I_ready = 1'b1;
    tick; tick; tick; #1;
    chk("halt stays halted", 32'(halted), 32'd1);
    chk("halt stays I_rd", 32'(I_rd), 32'd0);
    chk("halt I_addr", 32'(I_addr), 32'd2);
    chk("halt illegal", 32'(illegal), 32'd1);
    I_ready = 1'b0;

    // Reset out of PARADO
    reset_n = 1'b0;
    #1;
    chk("rst2 halted", 32'(halted), 32'd0);
    chk("rst2 illegal", 32'(illegal), 32'd0);
    reset_n = 1'b1;
    tick; #1;
    fetch(16'h3105, 16'h0000, "post_rst");
    tick; #1;
    tick; #1;

    // Reset during an instruction stall at address 1
    tick; #1;
    chk("stall3 I_addr", 32'(I_addr), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst3 I_rd", 32'(I_rd), 32'd0);
    chk("rst3 I_addr", 32'(I_addr), 32'd0);
    reset_n = 1'b1;
    tick; #1;
    chk("restart I_rd", 32'(I_rd), 32'd1);
    chk("restart I_addr", 32'(I_addr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
